// File: rtl/eth_sma_master_if.sv
// Command/response channel between the MAC register block and the MDIO management master.
// The master modport is the command issuer; the slave modport is the MDIO engine.
interface eth_sma_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/eth_sma_master.sv
// Clause-22 MDC/MDIO master: serializes one read/write management frame per accepted command.
// Latency: rsp_valid 1 + 2*CLK_DIV*(PREAMBLE_BITS+33) cycles after acceptance.
// Backpressure: cmd_ready low for the whole frame; responses are single-cycle and never stall.
module eth_sma_master #(
    parameter int CLK_DIV       = 10,
    parameter int PREAMBLE_BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    eth_sma_master_if.slave host,
    output logic            eth_mdc,
    output logic            eth_mdio_o,
    output logic            eth_mdio_oen,
    input  logic            eth_mdio_i
);
    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_BITS - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [15:0] rsp_rdata_q;
    logic        ta_ack;
    logic [15:0] rd_shift;
    logic        lat_write;
    logic [4:0]  lat_phy;
    logic [4:0]  lat_reg;
    logic [15:0] lat_wdata;

    logic        bit_end;
    logic        sample_pt;
    state_t      nxt_state;
    logic [4:0]  nxt_cnt;
    logic        nxt_o;
    logic        nxt_oen;

    // eth_mdc doubles as the half-bit phase: low half first, high half second.
    assign bit_end   = eth_mdc && (div_cnt == DIV_LAST);
    assign sample_pt = eth_mdc && (div_cnt == 8'd0);

    assign host.cmd_ready = cmd_ready_q;
    assign host.busy      = ~cmd_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;
    assign host.rsp_err   = rsp_err_q;

    // Next bit position and the MDIO value/enable to present for it.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = bit_cnt - 5'd1;
        if (bit_cnt == 5'd0) begin
            unique case (state)
                S_PRE:   begin nxt_state = S_ST;    nxt_cnt = 5'd1;  end
                S_ST:    begin nxt_state = S_OP;    nxt_cnt = 5'd1;  end
                S_OP:    begin nxt_state = S_PHYAD; nxt_cnt = 5'd4;  end
                S_PHYAD: begin nxt_state = S_REGAD; nxt_cnt = 5'd4;  end
                S_REGAD: begin nxt_state = S_TA;    nxt_cnt = 5'd1;  end
                S_TA:    begin nxt_state = S_DATA;  nxt_cnt = 5'd15; end
                S_DATA:  begin nxt_state = S_DONE;  nxt_cnt = 5'd0;  end
                default: begin nxt_state = S_IDLE;  nxt_cnt = 5'd0;  end
            endcase
        end

        nxt_o   = 1'b0;
        nxt_oen = 1'b0;
        case (nxt_state)
            S_PRE:   nxt_o = 1'b1;
            S_ST:    nxt_o = ~nxt_cnt[0];
            S_OP:    nxt_o = lat_write ? ~nxt_cnt[0] : nxt_cnt[0];
            S_PHYAD: nxt_o = lat_phy[nxt_cnt[2:0]];
            S_REGAD: nxt_o = lat_reg[nxt_cnt[2:0]];
            S_TA: begin
                if (lat_write) nxt_o = nxt_cnt[0];
                else           nxt_oen = 1'b1;
            end
            S_DATA: begin
                if (lat_write) nxt_o = lat_wdata[nxt_cnt[3:0]];
                else           nxt_oen = 1'b1;
            end
            default: nxt_oen = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            div_cnt      <= 8'd0;
            bit_cnt      <= 5'd0;
            eth_mdc      <= 1'b0;
            eth_mdio_o   <= 1'b0;
            eth_mdio_oen <= 1'b1;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 16'd0;
            rsp_err_q    <= 1'b0;
            ta_ack       <= 1'b0;
            rd_shift     <= 16'd0;
            lat_write    <= 1'b0;
            lat_phy      <= 5'd0;
            lat_reg      <= 5'd0;
            lat_wdata    <= 16'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state == S_IDLE) begin
                div_cnt      <= 8'd0;
                eth_mdc      <= 1'b0;
                eth_mdio_o   <= 1'b0;
                eth_mdio_oen <= 1'b1;
                if (host.cmd_valid) begin
                    lat_write    <= host.cmd_write;
                    lat_phy      <= host.cmd_phy_addr;
                    lat_reg      <= host.cmd_reg_addr;
                    lat_wdata    <= host.cmd_wdata;
                    state        <= S_PRE;
                    bit_cnt      <= PRE_LAST;
                    eth_mdio_o   <= 1'b1;
                    eth_mdio_oen <= 1'b0;
                    cmd_ready_q  <= 1'b0;
                end
            end else begin
                if (sample_pt) begin
                    if (state == S_TA && bit_cnt == 5'd0) ta_ack <= eth_mdio_i;
                    if (state == S_DATA) rd_shift <= {rd_shift[14:0], eth_mdio_i};
                end

                if (div_cnt == DIV_LAST) begin
                    div_cnt <= 8'd0;
                    eth_mdc <= ~eth_mdc;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end

                // Drive changes coincide with MDC falling, giving a full low half of setup.
                if (bit_end) begin
                    state        <= nxt_state;
                    bit_cnt      <= nxt_cnt;
                    eth_mdio_o   <= nxt_o;
                    eth_mdio_oen <= nxt_oen;
                    if (state == S_DONE) begin
                        cmd_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= lat_write ? 16'd0 : rd_shift;
                        rsp_err_q   <= lat_write ? 1'b0 : ta_ack;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_eth_sma_master.sv
// Directed bench for eth_sma_master with an in-bench clause-22 PHY (address 1, reg[i] = i at start)
// on a pulled-up MDIO line, plus a second instance at CLK_DIV=2 / PREAMBLE_BITS=1 with no PHY.
module tb_eth_sma_master;
    localparam int CD       = 10;
    localparam int PB       = 32;
    localparam int LAT      = 1 + 2 * CD * (PB + 33);
    localparam int CD2      = 2;
    localparam int PB2      = 1;
    localparam int LAT2     = 1 + 2 * CD2 * (PB2 + 33);
    localparam logic [4:0] PHY_ADDR = 5'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_sma_master_if host_if ();
    eth_sma_master_if host2_if ();

    logic mdc, mdio_o, mdio_oen, mdio_in;
    logic mdc2, mdio_o2, mdio_oen2, mdio_in2;
    logic phy_oe = 1'b0;
    logic phy_do = 1'b1;

    assign mdio_in  = !mdio_oen ? mdio_o : (phy_oe ? phy_do : 1'b1);
    assign mdio_in2 = mdio_oen2 ? 1'b1 : mdio_o2;

    eth_sma_master #(.CLK_DIV(CD), .PREAMBLE_BITS(PB)) dut (
        .clk(clk), .rst(rst), .host(host_if),
        .eth_mdc(mdc), .eth_mdio_o(mdio_o), .eth_mdio_oen(mdio_oen), .eth_mdio_i(mdio_in)
    );

    eth_sma_master #(.CLK_DIV(CD2), .PREAMBLE_BITS(PB2)) dut2 (
        .clk(clk), .rst(rst), .host(host2_if),
        .eth_mdc(mdc2), .eth_mdio_o(mdio_o2), .eth_mdio_oen(mdio_oen2), .eth_mdio_i(mdio_in2)
    );

    // PHY model and line monitors, all edge-detected on the system clock.
    logic [15:0] phy_reg [32];
    logic        mdc_q = 1'b0;
    int          m_pre = 0;
    int          m_pos = -1;
    int          m_idle = 0;
    logic [31:0] m_sr = '0;
    logic [13:0] m_hdr = '0;
    logic [63:0] tx_sr = '0;
    int          tx_n = 0;
    int          rel_n = 0;
    int          rel_run = 0;
    int          last_gap = 0;
    int          rsp_cnt = 0;
    int          contention = 0;

    initial for (int i = 0; i < 32; i++) phy_reg[i] = 16'(i);

    always @(posedge clk) begin
        mdc_q  <= mdc;
        m_idle <= (mdc == mdc_q) ? m_idle + 1 : 0;
        if (host_if.rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (!mdio_oen && phy_oe) contention <= contention + 1;
        if (mdio_oen) rel_run <= rel_run + 1;
        else begin
            if (rel_run > 0) last_gap <= rel_run;
            rel_run <= 0;
        end
        if (mdc && !mdc_q) begin
            if (!mdio_oen) begin
                tx_sr <= {tx_sr[62:0], mdio_o};
                tx_n  <= tx_n + 1;
            end else begin
                rel_n <= rel_n + 1;
            end
            if (m_pos < 0) begin
                if (mdio_in) m_pre <= m_pre + 1;
                else begin
                    if (m_pre >= 1) begin
                        m_pos <= 1;
                        m_sr  <= '0;
                    end
                    m_pre <= 0;
                end
            end else begin
                m_sr <= {m_sr[30:0], mdio_in};
                if (m_pos == 13) m_hdr <= {m_sr[12:0], mdio_in};
                if (m_pos == 31) begin
                    m_pos <= -1;
                    if (m_hdr[13:10] == 4'b0101 && m_hdr[9:5] == PHY_ADDR)
                        phy_reg[m_hdr[4:0]] <= {m_sr[14:0], mdio_in};
                end else begin
                    m_pos <= m_pos + 1;
                end
            end
        end
        if (!mdc && mdc_q) begin
            if (m_pos >= 15 && m_hdr[13:10] == 4'b0110 && m_hdr[9:5] == PHY_ADDR) begin
                phy_oe <= 1'b1;
                phy_do <= (m_pos == 15) ? 1'b0 : phy_reg[m_hdr[4:0]][4'(31 - m_pos)];
            end else begin
                phy_oe <= 1'b0;
            end
        end
        // A stalled MDC means the frame was abandoned; go back to hunting for preamble.
        if (m_idle > 100) begin
            m_pos  <= -1;
            m_pre  <= 0;
            phy_oe <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command from a negedge with cmd_ready high; returns at the rsp_valid negedge.
    task automatic do_cmd(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, output int lat,
                          output logic [15:0] rd, output logic e);
        int t0;
        host_if.cmd_valid    = 1'b1;
        host_if.cmd_write    = w;
        host_if.cmd_phy_addr = pa;
        host_if.cmd_reg_addr = ra;
        host_if.cmd_wdata    = wd;
        t0 = cyc;
        @(negedge clk);
        host_if.cmd_valid    = 1'b0;
        host_if.cmd_write    = ~w;
        host_if.cmd_reg_addr = ~ra;
        host_if.cmd_wdata    = ~wd;
        lat = -1;
        rd  = 16'hxxxx;
        e   = 1'bx;
        for (int i = 0; i < LAT + 100; i++) begin
            if (host_if.rsp_valid) begin
                lat = cyc - t0;
                rd  = host_if.rsp_rdata;
                e   = host_if.rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        w;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        logic        exp_err;
        logic        chk_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          lat, t0, t1, n0, r0, rc, rise1, rise2;
        logic [15:0] rd;
        logic        e, prev_mdc2;
        logic [63:0] exp_stream;

        vecs[0] = '{1'b0, 5'd3, 5'd2,  16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 5'd1, 5'd3,  16'hCAFE, 16'h0000, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 5'd1, 5'd3,  16'h0000, 16'hCAFE, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 5'd2, 5'd3,  16'h1111, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 5'd1, 5'd3,  16'h0000, 16'hCAFE, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 5'd1, 5'd0,  16'h0F0F, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 5'd1, 5'd0,  16'h0000, 16'h0F0F, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 5'd1, 5'd31, 16'h0000, 16'h001F, 1'b0, 1'b1};

        host_if.cmd_valid = 1'b0;  host_if.cmd_write = 1'b0;
        host_if.cmd_phy_addr = '0; host_if.cmd_reg_addr = '0; host_if.cmd_wdata = '0;
        host2_if.cmd_valid = 1'b0; host2_if.cmd_write = 1'b0;
        host2_if.cmd_phy_addr = '0; host2_if.cmd_reg_addr = '0; host2_if.cmd_wdata = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", host_if.cmd_ready, 1);
        check("rst_busy",      host_if.busy, 0);
        check("rst_rsp_valid", host_if.rsp_valid, 0);
        check("rst_rsp_rdata", host_if.rsp_rdata, 0);
        check("rst_rsp_err",   host_if.rsp_err, 0);
        check("rst_mdc",       mdc, 0);
        check("rst_mdio_o",    mdio_o, 0);
        check("rst_mdio_oen",  mdio_oen, 1);

        // Write PHY 1 reg 0 = 0x1234 with bit-stream capture.
        n0 = tx_n; r0 = rel_n;
        host_if.cmd_valid = 1'b1; host_if.cmd_write = 1'b1;
        host_if.cmd_phy_addr = 5'd1; host_if.cmd_reg_addr = 5'd0; host_if.cmd_wdata = 16'h1234;
        t0 = cyc;
        @(negedge clk);
        host_if.cmd_valid = 1'b0;
        check("accept_ready_drop", host_if.cmd_ready, 0);
        check("accept_busy",       host_if.busy, 1);
        check("pre_first_oen",     mdio_oen, 0);
        check("pre_first_o",       mdio_o, 1);
        check("pre_first_mdc",     mdc, 0);
        lat = -1;
        for (int i = 0; i < LAT + 100; i++) begin
            if (host_if.rsp_valid) begin lat = cyc - t0; break; end
            @(negedge clk);
        end
        check("wr_latency",  lat, LAT);
        check("wr_rsp_err",  host_if.rsp_err, 0);
        check("wr_rsp_data", host_if.rsp_rdata, 0);
        check("wr_ready",    host_if.cmd_ready, 1);
        exp_stream = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1234};
        check("wr_stream",   tx_sr, exp_stream);
        check("wr_driven_n", tx_n - n0, 64);
        check("wr_idle_rel", rel_n - r0, 1);
        check("wr_phy_reg0", phy_reg[0], 16'h1234);

        // Read PHY 1 reg 2: MDIO released from TA through the idle bit.
        @(negedge clk);
        n0 = tx_n; r0 = rel_n;
        do_cmd(1'b0, 5'd1, 5'd2, 16'h0, lat, rd, e);
        check("rd2_latency",  lat, LAT);
        check("rd2_data",     rd, 16'h0002);
        check("rd2_err",      e, 0);
        check("rd2_driven_n", tx_n - n0, 46);
        check("rd2_rel_n",    rel_n - r0, 19);
        check("rd2_header",   tx_sr[13:0], 14'b01_10_00001_00010);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            do_cmd(vecs[i].w, vecs[i].pa, vecs[i].ra, vecs[i].wd, lat, rd, e);
            check($sformatf("vec%0d_latency", i), lat, LAT);
            check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            @(negedge clk);
            check($sformatf("vec%0d_pulse_width", i), host_if.rsp_valid, 0);
            check($sformatf("vec%0d_err_hold", i), host_if.rsp_err, e);
        end

        // cmd_valid held high: write then read of reg 0, second accepted in the rsp cycle.
        host_if.cmd_valid = 1'b1; host_if.cmd_write = 1'b1;
        host_if.cmd_phy_addr = 5'd1; host_if.cmd_reg_addr = 5'd0; host_if.cmd_wdata = 16'h1234;
        t0 = cyc;
        @(negedge clk);
        host_if.cmd_write = 1'b0;
        lat = -1;
        for (int i = 0; i < LAT + 100; i++) begin
            if (host_if.rsp_valid) begin lat = cyc - t0; break; end
            @(negedge clk);
        end
        check("b2b_wr_latency", lat, LAT);
        check("b2b_ready_in_rsp", host_if.cmd_ready, 1);
        t1 = cyc;
        @(negedge clk);
        host_if.cmd_valid = 1'b0;
        check("b2b_accepted", host_if.busy, 1);
        lat = -1;
        for (int i = 0; i < LAT + 100; i++) begin
            if (host_if.rsp_valid) begin lat = cyc - t1; break; end
            @(negedge clk);
        end
        check("b2b_rd_latency", lat, LAT);
        check("b2b_rd_data", host_if.rsp_rdata, 16'h1234);
        check("b2b_gap", last_gap, 2 * CD + 1);

        // Reset during DATA of a write to reg 5; the frame must vanish without a response.
        @(negedge clk);
        host_if.cmd_valid = 1'b1; host_if.cmd_write = 1'b1;
        host_if.cmd_phy_addr = 5'd1; host_if.cmd_reg_addr = 5'd5; host_if.cmd_wdata = 16'h7777;
        @(negedge clk);
        host_if.cmd_valid = 1'b0;
        repeat (50 * 2 * CD) @(negedge clk);
        check("abort_mid_frame_busy", host_if.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_mdc",       mdc, 0);
        check("abort_oen",       mdio_oen, 1);
        check("abort_ready",     host_if.cmd_ready, 1);
        check("abort_rsp_valid", host_if.rsp_valid, 0);
        rc = rsp_cnt;
        repeat (LAT + 100) @(negedge clk);
        check("abort_no_rsp", rsp_cnt, rc);
        do_cmd(1'b1, 5'd1, 5'd4, 16'hBEEF, lat, rd, e);
        check("beef_latency", lat, LAT);
        check("beef_reg4",    phy_reg[4], 16'hBEEF);
        check("beef_reg5",    phy_reg[5], 16'h0005);

        // CLK_DIV=2, PREAMBLE_BITS=1 instance with no PHY attached.
        @(negedge clk);
        host2_if.cmd_valid = 1'b1; host2_if.cmd_write = 1'b0;
        host2_if.cmd_phy_addr = 5'd1; host2_if.cmd_reg_addr = 5'd2;
        t0 = cyc;
        @(negedge clk);
        host2_if.cmd_valid = 1'b0;
        prev_mdc2 = 1'b0; rise1 = -1; rise2 = -1; lat = -1;
        for (int i = 0; i < LAT2 + 50; i++) begin
            if (host2_if.rsp_valid) begin lat = cyc - t0; break; end
            if (mdc2 && !prev_mdc2) begin
                if (rise1 < 0) rise1 = cyc;
                else if (rise2 < 0) rise2 = cyc;
            end
            prev_mdc2 = mdc2;
            @(negedge clk);
        end
        check("div2_first_rise", rise1 - t0, 1 + CD2);
        check("div2_mdc_period", rise2 - rise1, 2 * CD2);
        check("div2_latency",    lat, LAT2);
        check("div2_err",        host2_if.rsp_err, 1);
        check("div2_rdata",      host2_if.rsp_rdata, 16'hFFFF);

        check("mdio_contention", contention, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
